// File: rtl/fft8_bitrev_buffer_if.sv
// Stream bundle around the bit-reverse reorder buffer.
// Signal names are written from the buffer's point of view: i_* flow into it and o_* flow out of it.
// The slave modport is the buffer itself.
// The master modport is whoever feeds the input stream and drains the output stream.
interface fft8_bitrev_buffer_if #(
    parameter int DATA_W = 32,
    parameter int N      = 8
);
    localparam int LOG2N = $clog2(N);

    // upstream sample stream (natural order)
    logic              i_valid;
    logic              o_ready;
    logic [DATA_W-1:0] i_data_re;
    logic [DATA_W-1:0] i_data_im;

    // downstream sample stream (bit-reversed order)
    logic              o_valid;
    logic              i_ready;
    logic [DATA_W-1:0] o_data_re;
    logic [DATA_W-1:0] o_data_im;
    logic [LOG2N-1:0]  o_index;
    logic              o_sop;
    logic              o_eop;

    modport slave (
        input  i_valid, i_data_re, i_data_im, i_ready,
        output o_ready, o_valid, o_data_re, o_data_im, o_index, o_sop, o_eop
    );

    modport master (
        output i_valid, i_data_re, i_data_im, i_ready,
        input  o_ready, o_valid, o_data_re, o_data_im, o_index, o_sop, o_eop
    );
endinterface

// File: rtl/fft8_bitrev_buffer.sv
// Input reorder stage for the 8-point radix-2 DIT FFT.
// Collects one frame of N complex samples in natural order.
// It then replays the frame in bit-reversed index order, so that butterfly stage 1 sees its operand pairs adjacent.
// Sample words are moved bit-exact; nothing is interpreted as floating point.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_FILL  | accepting input beats into mem[wr_ptr]; output stream idle
// S_DRAIN | presenting mem[bitrev(rd_ptr)] downstream; input stalled
module fft8_bitrev_buffer #(
    parameter int DATA_W = 32,
    parameter int N      = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    fft8_bitrev_buffer_if.slave  bus
);
    localparam int LOG2N = $clog2(N);
    localparam logic [LOG2N-1:0] PTR_LAST = LOG2N'(N - 1);

    typedef enum logic {
        S_FILL  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t                  r_state;
    logic [LOG2N-1:0]        r_wr_ptr;
    logic [LOG2N-1:0]        r_rd_ptr;
    logic                    r_ready;
    logic                    r_valid;
    logic [2*DATA_W-1:0]     r_mem [N];

    logic                    w_in_fire;
    logic                    w_out_fire;
    logic [LOG2N-1:0]        w_rd_addr;
    logic [2*DATA_W-1:0]     w_rd_word;

    // Reverse the LOG2N-bit index: output slot k reads natural sample bitrev(k).
    function automatic logic [LOG2N-1:0] f_bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int b = 0; b < LOG2N; b++) begin
            r[b] = a[LOG2N-1-b];
        end
        return r;
    endfunction

    assign w_in_fire  = bus.i_valid && r_ready;
    assign w_out_fire = r_valid && bus.i_ready;
    assign w_rd_addr  = f_bitrev(r_rd_ptr);
    assign w_rd_word  = r_mem[w_rd_addr];

    // Fill/drain sequencing.
    // Reset and clear return to an empty FILL state.
    // Ready and valid are registered alongside the state.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_state  <= S_FILL;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_in_fire) begin
                        if (r_wr_ptr == PTR_LAST) begin
                            r_wr_ptr <= '0;
                            r_state  <= S_DRAIN;
                            r_ready  <= 1'b0;
                            r_valid  <= 1'b1;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_out_fire) begin
                        if (r_rd_ptr == PTR_LAST) begin
                            r_rd_ptr <= '0;
                            r_state  <= S_FILL;
                            r_ready  <= 1'b1;
                            r_valid  <= 1'b0;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state  <= S_FILL;
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_ready  <= 1'b1;
                    r_valid  <= 1'b0;
                end
            endcase
        end
    end

    // Sample storage.
    // It is left unreset: contents are only ever read after a full frame has been written.
    always_ff @(posedge i_clk) begin
        if (w_in_fire) begin
            r_mem[r_wr_ptr] <= {bus.i_data_re, bus.i_data_im};
        end
    end

    assign bus.o_ready   = r_ready;
    assign bus.o_valid   = r_valid;
    // The data and index outputs are gated to zero while idle, so the array contents never leak out as X.
    assign bus.o_data_re = r_valid ? w_rd_word[2*DATA_W-1:DATA_W] : '0;
    assign bus.o_data_im = r_valid ? w_rd_word[DATA_W-1:0]        : '0;
    assign bus.o_index   = r_valid ? w_rd_addr                    : '0;
    assign bus.o_sop     = r_valid && (r_rd_ptr == '0);
    assign bus.o_eop     = r_valid && (r_rd_ptr == PTR_LAST);
endmodule

// File: tb/tb_fft8_bitrev_buffer.sv
// Self-checking bench for fft8_bitrev_buffer.
// A queue-based frame model predicts every output on every cycle.
// Literal expectations pin the reorder, backpressure, abort and special-value cases.
module tb_fft8_bitrev_buffer;
    localparam int DW = 32;
    localparam int NS = 8;

    logic clk;
    logic rst_n;
    logic clear;

    fft8_bitrev_buffer_if #(.DATA_W(DW), .N(NS)) bus ();

    fft8_bitrev_buffer #(.DATA_W(DW), .N(NS)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clear (clear),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] re;
        logic [31:0] im;
        int          idx;
    } smp_t;

    smp_t in_q[$];
    smp_t out_q[$];
    smp_t cap[$];
    bit   m_fill = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int brev3(input int i);
        return ((i & 1) * 4) + (i & 2) + ((i >> 2) & 1);
    endfunction

    // Per-cycle compare against the frame model, followed by the model update from this cycle's inputs.
    always @(negedge clk) begin
        smp_t s;
        logic [31:0] e_re, e_im;
        int e_idx;
        bit e_sop, e_eop;
        e_re = '0; e_im = '0; e_idx = 0; e_sop = 0; e_eop = 0;
        if (!m_fill) begin
            e_re  = out_q[0].re;
            e_im  = out_q[0].im;
            e_idx = out_q[0].idx;
            e_sop = (out_q.size() == NS);
            e_eop = (out_q.size() == 1);
        end
        chk("o_ready", 64'(bus.o_ready), 64'(m_fill));
        chk("o_valid", 64'(bus.o_valid), 64'(!m_fill));
        chk("o_data_re", 64'(bus.o_data_re), 64'(e_re));
        chk("o_data_im", 64'(bus.o_data_im), 64'(e_im));
        chk("o_index", 64'(bus.o_index), 64'(e_idx));
        chk("o_sop", 64'(bus.o_sop), 64'(e_sop));
        chk("o_eop", 64'(bus.o_eop), 64'(e_eop));

        if (rst_n && !clear && bus.o_valid && bus.i_ready) begin
            s.re = bus.o_data_re; s.im = bus.o_data_im; s.idx = int'(bus.o_index);
            cap.push_back(s);
        end

        if (!rst_n || clear) begin
            in_q.delete();
            out_q.delete();
            m_fill = 1'b1;
        end else if (m_fill) begin
            if (bus.i_valid) begin
                s.re = bus.i_data_re; s.im = bus.i_data_im; s.idx = in_q.size();
                in_q.push_back(s);
                if (in_q.size() == NS) begin
                    for (int k = 0; k < NS; k++) out_q.push_back(in_q[brev3(k)]);
                    in_q.delete();
                    m_fill = 1'b0;
                end
            end
        end else if (bus.i_ready) begin
            void'(out_q.pop_front());
            if (out_q.size() == 0) m_fill = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one input beat and wait until it is accepted; the wait is bounded.
    task automatic push(input logic [31:0] re, input logic [31:0] im);
        bit acc;
        int t;
        acc = 0; t = 0;
        bus.i_valid = 1'b1;
        bus.i_data_re = re;
        bus.i_data_im = im;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = bus.o_ready;
            tick();
            t++;
        end
        if (!acc) chk("push_timeout", 64'd0, 64'd1);
        bus.i_valid = 1'b0;
    endtask

    // Stall downstream for the given number of cycles, then take one output beat.
    task automatic pull(input int stall);
        bit acc;
        int t;
        acc = 0; t = 0;
        bus.i_ready = 1'b0;
        repeat (stall) tick();
        bus.i_ready = 1'b1;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = bus.o_valid;
            tick();
            t++;
        end
        if (!acc) chk("pull_timeout", 64'd0, 64'd1);
        bus.i_ready = 1'b0;
    endtask

    logic [31:0] ramp_re [NS];
    logic [31:0] req_re  [NS];
    int          req_idx [NS];
    logic [31:0] fr_re   [NS];
    logic [31:0] fr_im   [NS];

    task automatic check_ramp_capture(input string tag);
        chk({tag, "_count"}, 64'(cap.size()), 64'(NS));
        for (int k = 0; k < NS && k < cap.size(); k++) begin
            chk({tag, "_re"}, 64'(cap[k].re), 64'(req_re[k]));
            chk({tag, "_im"}, 64'(cap[k].im), 64'(req_re[k] ^ 32'h8000_0000));
            chk({tag, "_idx"}, 64'(cap[k].idx), 64'(req_idx[k]));
        end
    endtask

    initial begin
        ramp_re = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
                    32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000};
        req_re  = '{32'h00000000, 32'h40800000, 32'h40000000, 32'h40C00000,
                    32'h3F800000, 32'h40A00000, 32'h40400000, 32'h40E00000};
        req_idx = '{0, 4, 2, 6, 1, 5, 3, 7};

        rst_n = 1'b0; clear = 1'b0;
        bus.i_valid = 1'b0; bus.i_ready = 1'b0;
        bus.i_data_re = '0; bus.i_data_im = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_ready", 64'(bus.o_ready), 64'd1);
        chk("reset_valid", 64'(bus.o_valid), 64'd0);
        rst_n = 1'b1;
        tick();

        // Ramp frame, with handshake checks and a 5-cycle stall at beat 3.
        cap.delete();
        for (int k = 0; k < NS; k++) push(ramp_re[k], ramp_re[k] ^ 32'h8000_0000);
        @(negedge clk);
        chk("ready_drop", 64'(bus.o_ready), 64'd0);
        chk("first_sop", 64'(bus.o_sop), 64'd1);
        tick();
        for (int k = 0; k < 3; k++) pull(0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_hold_re", 64'(bus.o_data_re), 64'h40C00000);
            chk("bp_hold_idx", 64'(bus.o_index), 64'd6);
            tick();
        end
        for (int k = 3; k < NS; k++) pull(0);
        @(negedge clk);
        chk("ready_back", 64'(bus.o_ready), 64'd1);
        tick();
        check_ramp_capture("ramp");

        // Sparse input, then i_valid held high with junk data throughout the drain.
        cap.delete();
        for (int k = 0; k < NS; k++) begin
            push(ramp_re[k], ramp_re[k] ^ 32'h8000_0000);
            tick();
        end
        bus.i_valid = 1'b1;
        bus.i_data_re = 32'hDEADBEEF;
        bus.i_data_im = 32'hDEADBEEF;
        for (int k = 0; k < NS; k++) pull(k % 2);
        bus.i_valid = 1'b0;
        tick();
        check_ramp_capture("sparse");

        // Abort after 4 input beats, then a full frame of 1.0.
        cap.delete();
        for (int k = 0; k < 4; k++) push(32'h40E00000, 32'h0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int k = 0; k < NS; k++) push(32'h3F800000, 32'h3F800000);
        for (int k = 0; k < NS; k++) pull(0);
        chk("abort_count", 64'(cap.size()), 64'(NS));
        for (int k = 0; k < cap.size(); k++) chk("abort_re", 64'(cap[k].re), 64'h3F800000);

        // Reset during drain beat 2, then a ramp frame.
        for (int k = 0; k < NS; k++) push(32'h12345678, 32'h9ABCDEF0);
        pull(0); pull(0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_drain_valid", 64'(bus.o_valid), 64'd0);
        tick();
        cap.delete();
        for (int k = 0; k < NS; k++) push(ramp_re[k], ramp_re[k] ^ 32'h8000_0000);
        for (int k = 0; k < NS; k++) pull(0);
        check_ramp_capture("post_rst");

        // Special values: NaN at input 1, -Inf at input 2, -0.0 at input 3.
        cap.delete();
        for (int k = 0; k < NS; k++) begin
            fr_re[k] = 32'h41000000 + 32'(k);
            fr_im[k] = 32'h0;
        end
        fr_re[1] = 32'h7FC00000; fr_re[2] = 32'hFF800000; fr_re[3] = 32'h80000000;
        fr_im[1] = 32'hFF800000; fr_im[3] = 32'h7FC00000;
        for (int k = 0; k < NS; k++) push(fr_re[k], fr_im[k]);
        for (int k = 0; k < NS; k++) pull(0);
        if (cap.size() == NS) begin
            chk("nan_slot", 64'(cap[4].re), 64'h7FC00000);
            chk("ninf_slot", 64'(cap[2].re), 64'hFF800000);
            chk("nzero_slot", 64'(cap[6].re), 64'h80000000);
            chk("im_ninf_slot", 64'(cap[4].im), 64'hFF800000);
            chk("im_nan_slot", 64'(cap[6].im), 64'h7FC00000);
        end else begin
            chk("special_count", 64'(cap.size()), 64'(NS));
        end

        // Randomized frames with random input gaps and output stalls.
        for (int f = 0; f < 12; f++) begin
            for (int k = 0; k < NS; k++) begin
                push($urandom, $urandom);
                repeat ($urandom_range(0, 2)) tick();
            end
            for (int k = 0; k < NS; k++) pull($urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
